main_mem_arbiter: RTL

Shares the single read/write port of `main_mem` among up to `NREQ` requesters: core, front-panel load/look logic, and stdin/stdout dump engines. The block provides round-robin arbitration, a per-requester lock for back-to-back transactions, and a grant that holds until the memory accepts the request. It also routes each read response to its owner one cycle after acceptance. It sits between the requesters and `main_mem` and replaces the ad-hoc mux in the system top.

---
 rtl/main_mem_arbiter_pkg.sv | 18 +
 rtl/main_mem_arbiter_rr_pick.sv | 34 +++
 rtl/main_mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// Shared constants and types for the main_mem port arbiter.
// Requester indices match the wiring order used in the system top.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } arb_state_e;

    localparam int REQ_CORE  = 0;
    localparam int REQ_PANEL = 1;
    localparam int REQ_DUMP  = 2;

endpackage

// File: rtl/main_mem_arbiter_rr_pick.sv
// Cyclic priority encoder: first set request at or after ptr_i, wrapping at N.
// ptr_i must be below N; the sum is kept one bit wider so non-power-of-two N wraps exactly.
module rr_pick #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] win_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                win_o = idx;
            end
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing the single main_mem port among NREQ requesters,
// with per-requester lock and one-cycle read-response routing.
module main_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NREQ   = 3,
    parameter  int ADDR_W = MEM_ADDR_W,
    parameter  int DATA_W = MEM_DATA_W,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NREQ-1:0]              req_val_i,
    input  logic [NREQ-1:0]              req_wen_i,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr_i,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_wdata_i,
    input  logic [NREQ-1:0]              req_lock_i,
    output logic [NREQ-1:0]              req_rdy_o,
    output logic [NREQ-1:0]              req_rvalid_o,
    output logic [DATA_W-1:0]            req_rdata_o,
    output logic                         mem_val_o,
    output logic                         mem_wen_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    input  logic                         mem_rdy_i,
    input  logic [DATA_W-1:0]            mem_rdata_i,
    output logic [IW-1:0]                owner_o,
    output logic                         busy_o,
    output arb_state_e                   dbg_state_o,
    output logic [IW-1:0]                dbg_rr_ptr_o
);

    // Handshake: a requester raises val and holds val/wen/addr/wdata stable until its
    // req_rdy_o bit is seen high; a transfer happens exactly when mem_val_o && mem_rdy_i.

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          rd_pend_q, rd_pend_d;
    logic [IW-1:0] rd_id_q, rd_id_d;

    logic [IW-1:0] pick_win;
    logic          pick_any;
    logic [IW-1:0] fwd_idx;
    logic          fwd_val;
    logic          fwd_wen;
    logic          fire;
    logic [IW-1:0] next_ptr;

    rr_pick #(.N(NREQ)) u_pick (
        .req_i (req_val_i),
        .ptr_i (rr_ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    always_comb begin
        fwd_idx  = (state_q == IDLE) ? pick_win : owner_q;
        fwd_val  = !rst_i && ((state_q == IDLE) ? pick_any : req_val_i[owner_q]);
        fwd_wen  = req_wen_i[fwd_idx];
        fire     = fwd_val && mem_rdy_i;
        next_ptr = (fwd_idx == IW'(NREQ-1)) ? '0 : fwd_idx + IW'(1);
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        rd_pend_d = fire && !fwd_wen;
        rd_id_d   = fire ? fwd_idx : rd_id_q;
        case (state_q)
            IDLE: begin
                if (fwd_val) begin
                    owner_d = pick_win;
                    if (!mem_rdy_i) begin
                        state_d = PENDING;
                    end else if (req_lock_i[pick_win]) begin
                        state_d = LOCKED;
                    end else begin
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            PENDING: begin
                // A dropped val abandons the request without completing it.
                if (!req_val_i[owner_q]) begin
                    state_d = IDLE;
                end else if (mem_rdy_i) begin
                    if (req_lock_i[owner_q]) begin
                        state_d = LOCKED;
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            LOCKED: begin
                if (!req_lock_i[owner_q] && (!req_val_i[owner_q] || mem_rdy_i)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign mem_val_o   = fwd_val;
    assign mem_wen_o   = fwd_val && fwd_wen;
    assign mem_addr_o  = fwd_val ? req_addr_i[fwd_idx]  : '0;
    assign mem_wdata_o = fwd_val ? req_wdata_i[fwd_idx] : '0;
    assign req_rdy_o   = fire ? (NREQ'(1) << fwd_idx) : '0;

    assign req_rvalid_o = (rd_pend_q && !rst_i) ? (NREQ'(1) << rd_id_q) : '0;
    assign req_rdata_o  = (rd_pend_q && !rst_i) ? mem_rdata_i : '0;

    assign owner_o      = owner_q;
    assign busy_o       = (state_q != IDLE);
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule
